// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side handshake bundle for the UART receive sequencer.
// The receiver drives the byte and status flags. The consumer drives the acknowledge.
interface uart_rx_ctrl_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       stop_err;
    logic       overrun;
    logic       data_ack;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output stop_err,
        output overrun,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  stop_err,
        input  overrun,
        output data_ack
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. It synchronises rx, times the bit centres from the oversampled tick,
// deframes start/8 data/parity/stop, and presents the byte over a valid/ack handshake.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            baud_tick,
    input  logic            rx,
    input  logic            parity_odd,
    output logic            busy,
    uart_rx_ctrl_if.master  rx_if
);
    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shreg_reg, shreg_next;
    logic            podd_reg, podd_next;
    logic            perr_reg, perr_next;
    logic            stop_bit_reg, stop_bit_next;
    logic            commit_reg, commit_next;
    logic [1:0]      sync_reg;
    logic            rx_s;
    logic            tick_half;
    logic            tick_last;

    // Idle-high reset value, so leaving reset cannot look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end
    assign rx_s = sync_reg[1];

    assign tick_half = (tick_cnt_reg == TW'(OVERSAMPLE / 2 - 1));
    assign tick_last = (tick_cnt_reg == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            podd_reg     <= 1'b0;
            perr_reg     <= 1'b0;
            stop_bit_reg <= 1'b1;
            commit_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
            podd_reg     <= podd_next;
            perr_reg     <= perr_next;
            stop_bit_reg <= stop_bit_next;
            commit_reg   <= commit_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;
        podd_next     = podd_reg;
        perr_next     = perr_reg;
        stop_bit_next = stop_bit_reg;
        commit_next   = 1'b0;

        if (baud_tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_next    = S_START;
                        tick_cnt_next = '0;
                        podd_next     = parity_odd;
                        perr_next     = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_half) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_last) begin
                        tick_cnt_next = '0;
                        shreg_next    = {rx_s, shreg_reg[7:1]};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_last) begin
                        tick_cnt_next = '0;
                        perr_next     = ((^{shreg_reg, rx_s}) != podd_reg);
                        state_next    = S_STOP;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_last) begin
                        tick_cnt_next = '0;
                        stop_bit_next = rx_s;
                        commit_next   = 1'b1;
                        state_next    = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // A commit takes priority over an ack. An ack on the same clk only suppresses overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_if.data_out   <= 8'h00;
            rx_if.data_valid <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.stop_err   <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end else if (commit_reg) begin
            rx_if.data_out   <= shreg_reg;
            rx_if.data_valid <= 1'b1;
            rx_if.parity_err <= perr_reg & (PARITY_EN != 0);
            rx_if.stop_err   <= ~stop_bit_reg;
            rx_if.overrun    <= rx_if.data_valid & ~rx_if.data_ack;
        end else if (rx_if.data_ack && rx_if.data_valid) begin
            rx_if.data_valid <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.stop_err   <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end
    end

    assign busy = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames for uart_rx_ctrl. The results are compared against a
// frame-level model of the byte/flag/handshake rules.
module tb_uart_rx_ctrl;
    localparam int OS = 16;
    localparam int NB = 11;
    // rx to rx_s takes 2 clks, then half a bit to the start centre, then 10 more bits to the stop
    // centre, then the commit clk. The first loop index where valid is visible is one clk later.
    localparam int LAT_C    = 2 + OS / 2 + OS * (NB - 1) + 2;
    localparam int COMMIT_C = LAT_C - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_tick = 1'b1;
    logic rx = 1'b1;
    logic parity_odd = 1'b0;
    logic busy;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_EN(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .parity_odd (parity_odd),
        .busy       (busy),
        .rx_if      (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_perr = 1'b0;
    logic       m_serr = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"},  32'(bus.data_out),   32'(m_data));
        check({tag, "_valid"}, 32'(bus.data_valid), 32'(m_valid));
        check({tag, "_perr"},  32'(bus.parity_err), 32'(m_perr));
        check({tag, "_serr"},  32'(bus.stop_err),   32'(m_serr));
        check({tag, "_ovr"},   32'(bus.overrun),    32'(m_ovr));
    endtask

    // The parity check passes when the count of ones in data plus parity bit has the parity selected by parity_odd.
    function automatic logic exp_perr(input logic [7:0] d, input logic p, input logic po);
        int ones;
        ones = $countones(d) + int'(p);
        return ((ones % 2) != int'(po));
    endfunction

    function automatic logic even_p(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_serr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_serr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_ack();
        bus.data_ack = 1'b1;
        @(posedge clk); #1;
        bus.data_ack = 1'b0;
        model_ack();
    endtask

    // One frame. Loop index c is driven right after edge F+c-1 and is seen at edge F+c.
    // parity_odd flips mid-frame, so the receiver must use the value it latched at start detect.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic po,
                              input int ack_c, output int first_v);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        first_v = -1;
        for (int c = 0; c < NB * OS; c++) begin
            if (first_v < 0 && bus.data_valid === 1'b1) first_v = c;
            rx = bits[c / OS];
            parity_odd = (c < 40) ? po : ~po;
            bus.data_ack = (c == ack_c);
            @(posedge clk); #1;
        end
        bus.data_ack = 1'b0;
        if (ack_c >= 0 && ack_c < COMMIT_C) model_ack();
        m_ovr   = m_valid && (ack_c != COMMIT_C);
        m_valid = 1'b1;
        m_data  = d;
        m_perr  = exp_perr(d, p, po);
        m_serr  = ~s;
        if (ack_c > COMMIT_C) model_ack();
    endtask

    initial begin
        int fv;
        logic busy_seen;
        logic [7:0] d;
        logic po, wrong;
        int sel, ack_c;

        bus.data_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_busy", 32'(busy), 32'(0));
        reset_n = 1'b1;
        hold(1'b1, 20);

        // An A5 frame with even parity, followed by an exact latency check.
        send_frame(8'hA5, even_p(8'hA5), 1'b1, 1'b0, -1, fv);
        check("t1_latency", 32'(fv), 32'(LAT_C));
        check_all("t1");
        do_ack();
        check_all("t1_ack");

        // A 3C frame with odd parity selected and the parity bit chosen wrong.
        send_frame(8'h3C, ~even_p(8'h3C) ^ 1'b1, 1'b1, 1'b1, -1, fv);
        check_all("t2");
        check("t2_perr_set", 32'(bus.parity_err), 32'(1));
        do_ack();
        check_all("t2_ack");
        hold(1'b1, OS);

        // A short low glitch, which is rejected at the start-bit centre.
        busy_seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            rx = (c < 5) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        check("t3_busy_pulse", 32'(busy_seen), 32'(1));
        check("t3_busy_idle", 32'(busy), 32'(0));
        check_all("t3");

        // A break: the stop bit is 0 and rx stays low for 40 bit times.
        send_frame(8'h00, even_p(8'h00), 1'b0, 1'b0, -1, fv);
        hold(1'b0, 40 * OS);
        check_all("t4_break");
        check("t4_busy_break", 32'(busy), 32'(1));
        hold(1'b1, 2 * OS);
        check("t4_busy_idle", 32'(busy), 32'(0));
        do_ack();
        send_frame(8'h55, even_p(8'h55), 1'b1, 1'b0, -1, fv);
        check_all("t4_after");
        do_ack();

        // An overrun, then the same frame pair with an ack on the commit clk of the second frame.
        send_frame(8'h11, even_p(8'h11), 1'b1, 1'b0, -1, fv);
        send_frame(8'h22, even_p(8'h22), 1'b1, 1'b0, -1, fv);
        check_all("t5_ovr");
        do_ack();
        send_frame(8'h11, even_p(8'h11), 1'b1, 1'b0, -1, fv);
        send_frame(8'h22, even_p(8'h22), 1'b1, 1'b0, COMMIT_C, fv);
        check_all("t5_ackcommit");

        // A reset in the middle of data bit 4, while an old byte is still valid.
        d = 8'h96;
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(d[i], OS);
        hold(d[4], OS / 2);
        check("t6_busy_pre", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst");
        check("t6_rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        hold(1'b1, 5);
        reset_n = 1'b1;
        hold(1'b1, 20);
        send_frame(8'h81, even_p(8'h81), 1'b1, 1'b0, -1, fv);
        check_all("t6_frame");
        do_ack();

        // Random frames: data, parity sense, occasional bad parity, and ack timing are all varied.
        for (int n = 0; n < 12; n++) begin
            d     = 8'($urandom);
            po    = 1'($urandom_range(0, 1));
            wrong = ($urandom_range(0, 3) == 0);
            sel   = $urandom_range(0, 3);
            case (sel)
                0: ack_c = -1;
                1: ack_c = 100;
                2: ack_c = COMMIT_C;
                default: ack_c = COMMIT_C + 2;
            endcase
            send_frame(d, even_p(d) ^ po ^ wrong, 1'b1, po, ack_c, fv);
            check_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
